// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the sequence-code lock.
package code_lock_pkg;

    // Lock operating states; 2'd3 is unused and recovers to ST_ARMED.
    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ALARM    = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions such as port widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/code_lock_seq_toggle_detect.sv
// Switch toggle detector: remembers last cycle's switch levels and reports
// which bits changed, whether any/exactly one changed, and the changed index.
module toggle_detect #(
    parameter int W     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic [W-1:0]     sw,
    output logic [W-1:0]     tgl,
    output logic             tgl_any,
    output logic             tgl_onehot,
    output logic [IDX_W-1:0] tgl_idx
);

    logic [W-1:0]     r_sw_q;
    logic [IDX_W-1:0] w_idx;

    // Capture switch levels every edge; during reset this is exactly the
    // required behaviour, so no toggle is seen on the first cycle after it.
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    always_ff @(posedge clock) begin
        r_sw_q <= sw;
    end

    assign tgl        = sw ^ r_sw_q;
    assign tgl_any    = |tgl;
    assign tgl_onehot = $onehot(tgl);

    // Encode the toggled bit position; only meaningful when tgl_onehot.
    always_comb begin
        // NOTE: assign a default before any conditional write, otherwise a latch is inferred.
        w_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (tgl[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign tgl_idx = w_idx;

endmodule

// File: rtl/code_lock_seq.sv
// Sequence-code lock: unlocks when the switches toggle in the programmed
// index order, relocks after UNLOCK_CYCLES, alarms after MAX_TRIES wrong
// sequences. Define CODE_LOCK_ALARM_TIMEOUT_EN to make the alarm clear after
// ALARM_CYCLES; otherwise the alarm is sticky until reset.
module code_lock_seq
    import code_lock_pkg::*;
#(
    parameter int SW_W          = 8,
    parameter int CODE_LEN      = 4,
    parameter int IDX_W         = 3,
    parameter int UNLOCK_CYCLES = 4,
    parameter int MAX_TRIES     = 3,
    parameter int ALARM_CYCLES  = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [SW_W-1:0]                  sw,
    input  logic [CODE_LEN*IDX_W-1:0]        code,
    output logic                             locked,
    output logic                             alarm,
    output logic [clog2(CODE_LEN+1)-1:0]     step,
    output logic [clog2(MAX_TRIES+1)-1:0]    fail_cnt
);

    localparam int STEP_W = clog2(CODE_LEN + 1);
    localparam int FAIL_W = clog2(MAX_TRIES + 1);
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
    // One timer serves both the unlock dwell and the alarm timeout.
    localparam int TMR_MAX = (UNLOCK_CYCLES > ALARM_CYCLES) ? UNLOCK_CYCLES : ALARM_CYCLES;
`else
    localparam int TMR_MAX = UNLOCK_CYCLES;
`endif
    localparam int TMR_W = clog2(TMR_MAX + 1);

    // Reject degenerate configurations at elaboration.
    if (CODE_LEN < 1 || UNLOCK_CYCLES < 1 || MAX_TRIES < 1 || ALARM_CYCLES < 1) begin : g_param_check
        $error("code_lock_seq: CODE_LEN, UNLOCK_CYCLES, MAX_TRIES and ALARM_CYCLES must be >= 1");
    end

    state_t              r_state,  w_state_nx;
    logic [STEP_W-1:0]   r_step,   w_step_nx;
    logic [FAIL_W-1:0]   r_fail,   w_fail_nx;
    logic [TMR_W-1:0]    r_timer,  w_timer_nx;
    logic                r_locked, w_locked_nx;
    logic                r_alarm,  w_alarm_nx;

    logic [SW_W-1:0]     w_tgl;
    logic                w_tgl_any;
    logic                w_tgl_onehot;
    logic [IDX_W-1:0]    w_tgl_idx;
    logic [IDX_W-1:0]    w_code_entry;

    toggle_detect #(
        .W     (SW_W),
        .IDX_W (IDX_W)
    ) u_toggle_detect (
        .clock      (clock),
        .sw         (sw),
        .tgl        (w_tgl),
        .tgl_any    (w_tgl_any),
        .tgl_onehot (w_tgl_onehot),
        .tgl_idx    (w_tgl_idx)
    );

    // The switch index expected next; step never exceeds CODE_LEN-1 here.
    assign w_code_entry = code[int'(r_step)*IDX_W +: IDX_W];

    // Next-state and next-output logic for the lock FSM.
    always_comb begin
        w_state_nx  = r_state;
        w_step_nx   = r_step;
        w_fail_nx   = r_fail;
        w_timer_nx  = r_timer;
        w_locked_nx = r_locked;
        w_alarm_nx  = r_alarm;
        case (r_state)
            ST_ARMED: begin
                w_locked_nx = 1'b1;
                w_alarm_nx  = 1'b0;
                if (w_tgl_any) begin
                    if (w_tgl_onehot && (w_tgl_idx == w_code_entry)) begin
                        if (r_step == STEP_W'(CODE_LEN - 1)) begin
                            w_state_nx  = ST_UNLOCKED;
                            w_step_nx   = '0;
                            w_fail_nx   = '0;
                            w_timer_nx  = '0;
                            w_locked_nx = 1'b0;
                        end else begin
                            w_step_nx = r_step + STEP_W'(1);
                        end
                    end else begin
                        // Wrong index or simultaneous toggles both count as a failure.
                        w_step_nx = '0;
                        if (r_fail != FAIL_W'(MAX_TRIES)) begin
                            w_fail_nx = r_fail + FAIL_W'(1);
                        end
                        if (r_fail == FAIL_W'(MAX_TRIES - 1)) begin
                            w_state_nx = ST_ALARM;
                            w_alarm_nx = 1'b1;
                            w_timer_nx = '0;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                // Toggles are ignored while open; the dwell is UNLOCKED_CYCLES edges.
                w_locked_nx = 1'b0;
                if (r_timer == TMR_W'(UNLOCK_CYCLES - 1)) begin
                    w_state_nx  = ST_ARMED;
                    w_timer_nx  = '0;
                    w_locked_nx = 1'b1;
                end else begin
                    w_timer_nx = r_timer + TMR_W'(1);
                end
            end
            ST_ALARM: begin
                w_step_nx   = '0;
                w_locked_nx = 1'b1;
                w_alarm_nx  = 1'b1;
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
                if (r_timer == TMR_W'(ALARM_CYCLES - 1)) begin
                    w_state_nx = ST_ARMED;
                    w_timer_nx = '0;
                    w_fail_nx  = '0;
                    w_alarm_nx = 1'b0;
                end else begin
                    w_timer_nx = r_timer + TMR_W'(1);
                end
`endif
            end
            default: begin
                w_state_nx  = ST_ARMED;
                w_step_nx   = '0;
                w_fail_nx   = '0;
                w_timer_nx  = '0;
                w_locked_nx = 1'b1;
                w_alarm_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_ARMED;
            r_step   <= '0;
            r_fail   <= '0;
            r_timer  <= '0;
            r_locked <= 1'b1;
            r_alarm  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_step   <= w_step_nx;
            r_fail   <= w_fail_nx;
            r_timer  <= w_timer_nx;
            r_locked <= w_locked_nx;
            r_alarm  <= w_alarm_nx;
        end
    end

    assign locked   = r_locked;
    assign alarm    = r_alarm;
    assign step     = r_step;
    assign fail_cnt = r_fail;

endmodule

// File: tb/tb_code_lock_seq.sv
// Self-checking bench for code_lock_seq: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// counter-based behavioural model.
module tb_code_lock_seq;

    localparam int SW_W          = 8;
    localparam int CODE_LEN      = 4;
    localparam int IDX_W         = 3;
    localparam int UNLOCK_CYCLES = 4;
    localparam int MAX_TRIES     = 3;
    localparam int ALARM_CYCLES  = 16;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [SW_W-1:0]           sw    = '0;
    logic [CODE_LEN*IDX_W-1:0] code;
    logic                      locked;
    logic                      alarm;
    logic [2:0]                step;
    logic [1:0]                fail_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    code_lock_seq #(
        .SW_W          (SW_W),
        .CODE_LEN      (CODE_LEN),
        .IDX_W         (IDX_W),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .MAX_TRIES     (MAX_TRIES),
        .ALARM_CYCLES  (ALARM_CYCLES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sw       (sw),
        .code     (code),
        .locked   (locked),
        .alarm    (alarm),
        .step     (step),
        .fail_cnt (fail_cnt)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int entry(input int i);
        logic [CODE_LEN*IDX_W-1:0] shifted;
        shifted = code >> (i * IDX_W);
        return int'(shifted[IDX_W-1:0]);
    endfunction

    // Behavioural model: progress through the code, failure count, and
    // remaining open / alarm cycles.
    int              m_progress  = 0;
    int              m_fails     = 0;
    int              m_open_left = 0;
    int              m_alarm_left = 0;
    bit              m_alarm     = 1'b0;
    bit              m_valid     = 1'b0;
    logic [SW_W-1:0] m_prev      = '0;

    always @(posedge clock) begin
        logic [SW_W-1:0] t;
        if (reset) begin
            m_prev      = sw;
            m_progress  = 0;
            m_fails     = 0;
            m_open_left = 0;
            m_alarm     = 1'b0;
            m_valid     = 1'b1;
        end else begin
            t      = sw ^ m_prev;
            m_prev = sw;
            if (m_alarm) begin
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
                m_alarm_left--;
                if (m_alarm_left == 0) begin
                    m_alarm = 1'b0;
                    m_fails = 0;
                end
`endif
            end else if (m_open_left > 0) begin
                m_open_left--;
            end else if (t != '0) begin
                if ($countones(t) == 1 && t == (SW_W'(1) << entry(m_progress))) begin
                    m_progress++;
                    if (m_progress == CODE_LEN) begin
                        m_progress  = 0;
                        m_fails     = 0;
                        m_open_left = UNLOCK_CYCLES;
                    end
                end else begin
                    m_progress = 0;
                    if (m_fails < MAX_TRIES) m_fails++;
                    if (m_fails == MAX_TRIES) begin
                        m_alarm      = 1'b1;
                        m_alarm_left = ALARM_CYCLES;
                    end
                end
            end
        end
    end

    // Scoreboard compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("sb_locked",   int'(locked),   (m_open_left > 0) ? 0 : 1);
            check("sb_alarm",    int'(alarm),    int'(m_alarm));
            check("sb_step",     int'(step),     m_progress);
            check("sb_fail_cnt", int'(fail_cnt), m_fails);
        end
    end

    task automatic apply(input logic [SW_W-1:0] v);
        sw = v;
        @(negedge clock);
    endtask

    task automatic toggle(input int b);
        logic [SW_W-1:0] m;
        m = SW_W'(1) << b;
        apply(sw ^ m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(sw);
    endtask

    task automatic enter_code();
        for (int i = 0; i < CODE_LEN; i++) toggle(entry(i));
    endtask

    initial begin
        int r;
        int hi;
        logic [SW_W-1:0] nsw;
        logic [SW_W-1:0] two;
        code = {3'd2, 3'd6, 3'd1, 3'd3};
        @(negedge clock);
        apply(sw);
        apply(sw);
        reset = 1'b0;
        check("rst_locked", int'(locked), 1);
        check("rst_alarm",  int'(alarm),  0);
        check("rst_step",   int'(step),   0);
        check("rst_fail",   int'(fail_cnt), 0);

        // Correct sequence unlocks for exactly UNLOCK_CYCLES cycles.
        toggle(3); check("t1_step1", int'(step), 1);
        toggle(1); check("t1_step2", int'(step), 2);
        toggle(6); check("t1_step3", int'(step), 3);
        toggle(2); check("t1_open", int'(locked), 0);
        check("t1_step0", int'(step), 0);
        idle(3);   check("t1_still_open", int'(locked), 0);
        idle(1);   check("t1_relocked", int'(locked), 1);
        check("t1_fail", int'(fail_cnt), 0);

        // Wrong third entry fails; then the correct code clears fail_cnt.
        toggle(3); check("t2_step1", int'(step), 1);
        toggle(1); check("t2_step2", int'(step), 2);
        toggle(5); check("t2_step0", int'(step), 0);
        check("t2_fail1", int'(fail_cnt), 1);
        check("t2_locked", int'(locked), 1);
        check("t2_alarm", int'(alarm), 0);
        enter_code();
        check("t2_open", int'(locked), 0);
        check("t2_fail0", int'(fail_cnt), 0);
        idle(UNLOCK_CYCLES);

        // Simultaneous toggles count as a failure.
        two = 8'b0000_1010;
        apply(sw ^ two);
        check("t4_fail", int'(fail_cnt), 1);
        check("t4_step", int'(step), 0);
        enter_code();
        check("t4_clear", int'(fail_cnt), 0);

        // Reset while unlocked with timer at 2.
        idle(2);
        reset = 1'b1;
        apply(sw);
        reset = 1'b0;
        check("t5u_locked", int'(locked), 1);
        check("t5u_fail", int'(fail_cnt), 0);
        idle(2);
        check("t5u_no_step", int'(step), 0);

        // Three wrong toggles raise the alarm; correct code is then ignored.
        toggle(0); check("t3_fail1", int'(fail_cnt), 1);
        toggle(0); check("t3_fail2", int'(fail_cnt), 2);
        toggle(0); check("t3_alarm", int'(alarm), 1);
        check("t3_fail3", int'(fail_cnt), 3);
        enter_code();
        check("t3_ignored", int'(locked), 1);
        check("t3_step", int'(step), 0);
        check("t3_alarm_held", int'(alarm), 1);

        // Reset while in alarm.
        reset = 1'b1;
        apply(sw);
        reset = 1'b0;
        check("t5a_alarm", int'(alarm), 0);
        check("t5a_fail", int'(fail_cnt), 0);
        check("t5a_locked", int'(locked), 1);
        idle(1);
        check("t5a_no_step", int'(step), 0);

`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
        // Alarm times out after exactly ALARM_CYCLES cycles.
        toggle(0); toggle(0); toggle(0);
        check("t6_alarm", int'(alarm), 1);
        hi = 1;
        for (int k = 0; k < 40 && alarm; k++) begin
            apply(sw);
            if (alarm) hi++;
        end
        check("t6_alarm_len", hi, 16);
        check("t6_alarm_off", int'(alarm), 0);
        check("t6_fail", int'(fail_cnt), 0);
        enter_code();
        check("t6_open", int'(locked), 0);
        idle(UNLOCK_CYCLES);
`endif

        // Randomized phase checked by the scoreboard.
        for (int n = 0; n < 1500; n++) begin
            r   = int'($urandom_range(0, 99));
            nsw = sw;
            if (r < 2) begin
                reset = 1'b1;
                code  = CODE_LEN*IDX_W'($urandom);
                apply(sw);
                reset = 1'b0;
            end else begin
                if (r >= 45 && r < 80) begin
                    nsw = sw ^ (SW_W'(1) << entry(m_progress));
                end else if (r >= 80 && r < 92) begin
                    nsw = sw ^ (SW_W'(1) << $urandom_range(0, SW_W - 1));
                end else if (r >= 92) begin
                    nsw = sw ^ SW_W'($urandom);
                end
                apply(nsw);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
